// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and types for the 12-key launch pad keypad
// scanner.
//   NUM_KEYS    - number of keys behind the 12:1 mux (codes 0..11)
//   KEY_CODE_W  - width of a key code / mux select code
//   KEY_STAR    - code of the star key
//   KEY_SHARP   - code of the sharp key
//   key_evt_t   - one press/release event {code, pressed}
package keypad_pkg;

  localparam int NUM_KEYS   = 12;
  localparam int KEY_CODE_W = 4;

  localparam logic [KEY_CODE_W-1:0] KEY_STAR  = 4'd10;
  localparam logic [KEY_CODE_W-1:0] KEY_SHARP = 4'd11;

  typedef struct packed {
    logic [KEY_CODE_W-1:0] code;
    logic                  pressed;
  } key_evt_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: debounce state for a single key.
//   clk, srst  - clock and synchronous active-high reset
//   sample_en  - high on the one clock per scan round where this key is sampled
//   sample     - mux output level for this key on that clock (1 = pressed)
//   state      - debounced level (registered)
//   toggle     - combinational pulse, high in the sample cycle whose sample
//                flips the debounced level; state changes on the following edge
module key_debounce #(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic sample_en,
  input  logic sample,
  output logic state,
  output logic toggle
);

  // Count of consecutive samples that disagree with the debounced level.
  localparam logic [3:0] LAST_CNT = 4'(DEBOUNCE_SCANS - 1);

  logic       state_reg;
  logic [3:0] cnt_reg;
  logic       differs;

  assign differs = sample_en && (sample != state_reg);
  // The flip is decided combinationally so the event can be captured on the
  // same edge that updates the debounced level.
  assign toggle  = differs && (cnt_reg == LAST_CNT);
  assign state   = state_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= 1'b0;
      cnt_reg   <= 4'd0;
    end else if (sample_en) begin
      if (!differs) begin
        cnt_reg <= 4'd0;
      end else if (toggle) begin
        state_reg <= ~state_reg;
        cnt_reg   <= 4'd0;
      end else begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: scanning controller for the 12-key launch pad keypad.
//   clk          - system clock
//   rst          - synchronous reset, active-high
//   B_out[3:0]   - select code into the 12:1 key mux, cycles 0..11
//   D_in         - selected key level from the mux, 1 = pressed
//   evt_valid    - event buffer holds an event
//   evt_ready    - consumer accepts the event this cycle
//   evt_code     - key code of the buffered event (10 = star, 11 = sharp)
//   evt_pressed  - 1 = press, 0 = release
//   key_state    - debounced level per key, bit k = code k
//   overflow     - sticky flag: an event was dropped on a full buffer
//   ovf_clr      - clears overflow (a drop in the same cycle wins)
// Each select code is held for SETTLE_CYCLES clocks; the mux output is
// sampled on the last clock of the dwell, then the select code advances.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [KEY_CODE_W-1:0] B_out,
  input  logic                  D_in,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [KEY_CODE_W-1:0] evt_code,
  output logic                  evt_pressed,
  output logic [NUM_KEYS-1:0]   key_state,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam logic [7:0]            LAST_DWELL = 8'(SETTLE_CYCLES - 1);
  localparam logic [KEY_CODE_W-1:0] LAST_CODE  = 4'(NUM_KEYS - 1);

  logic [7:0]            dwell_reg;
  logic [KEY_CODE_W-1:0] sel_reg;
  logic                  sample_cycle;

  logic [NUM_KEYS-1:0]   toggle;
  logic                  gen_evt;
  logic                  can_load;
  logic                  drop;

  key_evt_t              evt_reg;
  logic                  evt_valid_reg;
  logic                  overflow_reg;

  assign sample_cycle = (dwell_reg == LAST_DWELL);

  // Dwell counter and select sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_reg <= 8'd0;
      sel_reg   <= '0;
    end else if (sample_cycle) begin
      dwell_reg <= 8'd0;
      sel_reg   <= (sel_reg == LAST_CODE) ? '0 : sel_reg + 4'd1;
    end else begin
      dwell_reg <= dwell_reg + 8'd1;
    end
  end

  // One debouncer per key; only the key currently selected sees sample_en.
  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_deb (
        .clk      (clk),
        .srst     (rst),
        .sample_en(sample_cycle && (sel_reg == 4'(gi))),
        .sample   (D_in),
        .state    (key_state[gi]),
        .toggle   (toggle[gi])
      );
    end
  endgenerate

  // Only the selected key can toggle, so the event code is the select code
  // and the new level is the sampled level.
  assign gen_evt  = |toggle;
  assign can_load = !evt_valid_reg || evt_ready;
  assign drop     = gen_evt && !can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_reg <= 1'b0;
      evt_reg       <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      if (gen_evt && can_load) begin
        evt_valid_reg   <= 1'b1;
        evt_reg.code    <= sel_reg;
        evt_reg.pressed <= D_in;
      end else if (evt_ready) begin
        evt_valid_reg <= 1'b0;
      end

      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign B_out       = sel_reg;
  assign evt_valid   = evt_valid_reg;
  assign evt_code    = evt_reg.code;
  assign evt_pressed = evt_reg.pressed;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl with
// SETTLE_CYCLES=4, DEBOUNCE_SCANS=3. A reference model computes the expected
// scan position from elapsed clocks and keeps per-key debounce counts and a
// one-entry event buffer; every clock is compared against it. Table rows and
// hand-written sequences add scenario-level expectations.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int S     = 4;
  localparam int DB    = 3;
  localparam int ROUND = 12 * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  b_out;
  logic        d_in;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [3:0]  evt_code;
  logic        evt_pressed;
  logic [11:0] key_state;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  logic [11:0] keys = 12'h000;   // physical key levels behind the mux

  assign d_in = (b_out < 4'd12) ? keys[b_out] : 1'b0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rst(rst), .B_out(b_out), .D_in(d_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_pressed(evt_pressed), .key_state(key_state),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // ---------------- reference model ----------------
  int          m_t = 0;
  int          m_cnt [12];
  logic [11:0] m_state = '0;
  bit          m_valid = 0;
  int          m_code = 0;
  bit          m_pressed = 0;
  bit          m_ovf = 0;
  key_evt_t    ev_log[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_step();
    bit consume, gen, drop;
    int k, gcode;
    bit gp;
    if (rst) begin
      m_t = 0; m_state = '0; m_valid = 0; m_code = 0; m_pressed = 0; m_ovf = 0;
      for (int i = 0; i < 12; i++) m_cnt[i] = 0;
      return;
    end
    consume = m_valid && evt_ready;
    if (consume) begin
      ev_log.push_back('{code: 4'(m_code), pressed: m_pressed});
      $display("t=%0t event consumed code=%0d pressed=%0d", $time, m_code, m_pressed);
    end
    gen = 0; gcode = 0; gp = 0;
    if ((m_t % S) == S - 1) begin
      k = (m_t / S) % 12;
      if (keys[k] == m_state[k]) m_cnt[k] = 0;
      else begin
        m_cnt[k]++;
        if (m_cnt[k] == DB) begin
          m_state[k] = ~m_state[k];
          m_cnt[k] = 0;
          gen = 1; gcode = k; gp = keys[k];
        end
      end
    end
    drop = gen && m_valid && !consume;
    if (gen && !drop) begin
      m_valid = 1; m_code = gcode; m_pressed = gp;
    end else if (consume) m_valid = 0;
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_t++;
  endtask

  task automatic check_all();
    chk("b_out", b_out, (m_t / S) % 12);
    chk("b_out_range", int'(b_out <= 4'd11), 1);
    chk("evt_valid", evt_valid, m_valid);
    chk("key_state", key_state, m_state);
    chk("overflow", overflow, m_ovf);
    if (m_valid) begin
      chk("evt_code", evt_code, m_code);
      chk("evt_pressed", evt_pressed, m_pressed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [11:0] keys;
    int          rounds;
    bit          ready;
    logic [11:0] exp_state;
    int          exp_events;
    bit          exp_ovf;
    int          exp_code;
    bit          exp_pressed;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int n;
    for (int i = 0; i < 12; i++) m_cnt[i] = 0;

    //             name          keys    rnd rdy state  ev ovf code prs
    vecs.push_back('{"idle",       12'h000, 10, 1, 12'h000, 0, 0, 0,  0});
    vecs.push_back('{"press3",     12'h008,  5, 1, 12'h008, 1, 0, 3,  1});
    vecs.push_back('{"release3",   12'h000,  5, 1, 12'h000, 1, 0, 3,  0});
    vecs.push_back('{"glitch7",    12'h080,  2, 1, 12'h000, 0, 0, 0,  0});
    vecs.push_back('{"gap7",       12'h000,  2, 1, 12'h000, 0, 0, 0,  0});
    vecs.push_back('{"press7",     12'h080,  4, 1, 12'h080, 1, 0, 7,  1});
    vecs.push_back('{"release7",   12'h000,  4, 1, 12'h000, 1, 0, 7,  0});
    vecs.push_back('{"press01",    12'h003,  4, 1, 12'h003, 2, 0, 0,  1});
    vecs.push_back('{"release01",  12'h000,  4, 1, 12'h000, 2, 0, 0,  0});
    vecs.push_back('{"stall_ab",   12'hC00,  4, 0, 12'hC00, 0, 1, 0,  0});
    vecs.push_back('{"drain_ab",   12'hC00,  1, 1, 12'hC00, 1, 1, 10, 1});

    // Reset and check the reset state.
    rst = 1'b1;
    run(2);
    chk("rst_b_out", b_out, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", evt_code, 0);
    chk("rst_evt_pressed", evt_pressed, 0);
    chk("rst_key_state", key_state, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Latency: key 3 held from reset release; its 3rd sample is at clock 111,
    // so evt_valid shows after 112 clocks.
    keys = 12'h008;
    n = 0;
    while (n < 4 * ROUND && !evt_valid) begin
      tick();
      n++;
    end
    chk("press_latency", n, DB * ROUND - ROUND + 3 * S + S);
    chk("latency_key_state", key_state, 12'h008);
    keys = 12'h000;
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Table-driven scenarios.
    foreach (vecs[i]) begin
      ev_log.delete();
      keys = vecs[i].keys;
      evt_ready = vecs[i].ready;
      run(vecs[i].rounds * ROUND);
      chk({vecs[i].name, "_state"}, key_state, vecs[i].exp_state);
      chk({vecs[i].name, "_events"}, ev_log.size(), vecs[i].exp_events);
      chk({vecs[i].name, "_ovf"}, overflow, vecs[i].exp_ovf);
      if (ev_log.size() > 0 && vecs[i].exp_events > 0) begin
        chk({vecs[i].name, "_code"}, ev_log[0].code, vecs[i].exp_code);
        chk({vecs[i].name, "_pressed"}, ev_log[0].pressed, vecs[i].exp_pressed);
      end
    end

    // Clear overflow, then release star and sharp.
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    ev_log.delete();
    keys = 12'h000;
    run(4 * ROUND);
    chk("release_ab_events", ev_log.size(), 2);
    chk("release_ab_state", key_state, 0);

    // Reset mid-operation with key 9 held.
    keys = 12'h200;
    n = 0;
    while (n < 4 * ROUND && !key_state[9]) begin
      tick();
      n++;
    end
    chk("hold9_state", key_state[9], 1);
    run(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_b_out", b_out, 0);
    chk("mid_rst_key_state", key_state, 0);
    chk("mid_rst_evt_valid", evt_valid, 0);
    ev_log.delete();
    run(4 * ROUND);
    chk("after_rst_events", ev_log.size(), 1);
    if (ev_log.size() > 0) begin
      chk("after_rst_code", ev_log[0].code, 9);
      chk("after_rst_pressed", ev_log[0].pressed, 1);
    end

    // Randomized key activity with random backpressure and clears.
    for (int i = 0; i < 1500; i++) begin
      if ((i % 40) == 0) keys = 12'($urandom_range(0, 4095));
      evt_ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 63) == 0);
      tick();
    end
    ovf_clr = 1'b0;
    evt_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scanning controller for the 12-key launch pad keypad: digits 0-9, star and sharp.
- Drives the 4-bit select code into the 12:1 key mux (B_in side) and samples the mux output (D_out side).
- Debounces each key independently.
- Emits press/release events through a one-entry valid/ready buffer to the sound/LED logic, and exposes a live debounced key-state vector.

Parameters:
- SETTLE_CYCLES, 16: clocks each select code is held; the mux output is sampled on the last clock of the dwell (range 2..255).
- DEBOUNCE_SCANS, 4: consecutive differing samples of one key required to flip its debounced state (range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- B_out  output  4  key select code to the mux; only values 0..11 are ever driven
- D_in  input  1  selected key level from the mux, 1 = pressed
- evt_valid  output  1  event buffer holds an event
- evt_ready  input  1  consumer accepts the event this cycle
- evt_code  output  4  key code of the event (0-9, 10 = star, 11 = sharp)
- evt_pressed  output  1  1 = press, 0 = release
- key_state  output  12  debounced level per key; bit k = code k
- overflow  output  1  sticky: an event was dropped
- ovf_clr  input  1  clears overflow

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: B_out=0, dwell counter=0, key_state=0, all debounce counters=0, evt_valid=0, evt_code=0, evt_pressed=0, overflow=0.
- Scan sequencing:
  - The dwell counter runs 0..SETTLE_CYCLES-1.
  - On the last dwell cycle, D_in is sampled for key B_out. In the same cycle, B_out advances by one and wraps 11 -> 0, and the dwell counter returns to 0.
  - One scan round = 12*SETTLE_CYCLES clocks. Codes 12..15 are never output.
- Per-key debounce, evaluated only on that key's sample cycle:
  - If sample == key_state[k], cnt[k] = 0.
  - Otherwise cnt[k]++. When cnt[k] reaches DEBOUNCE_SCANS, key_state[k] toggles, cnt[k] = 0, and an event {k, new level} is generated.
  - With DEBOUNCE_SCANS=1, every change flips on the first sample.
  - A glitch shorter than DEBOUNCE_SCANS rounds produces no event and resets the count.
- Event buffer (one entry):
  - A generated event loads if the buffer is empty, or if evt_valid && evt_ready in the same cycle (simultaneous consume + load keeps evt_valid high with the new contents).
  - evt_valid, evt_code and evt_pressed update on the clock after the sample cycle.
  - evt_code and evt_pressed are held stable while evt_valid is high and evt_ready is low.
  - Full buffer and no ready: the new event is dropped, overflow is set, and key_state still updates.
  - At most one event per clock, since only one key is sampled per clock.
- overflow:
  - Cleared by ovf_clr.
  - If ovf_clr and a drop occur in the same cycle, the drop wins and overflow stays 1.
- Latency:
  - A press stable from before key k's sample slot yields key_state[k]=1 on the DEBOUNCE_SCANS-th sample cycle.
  - evt_valid is asserted 1 clock after that sample cycle.
  - Worst case from the D_in edge: DEBOUNCE_SCANS*12*SETTLE_CYCLES + 1 clocks.
- Reset mid-operation:
  - Pending events are discarded and the scan restarts at code 0.
  - Keys held through reset are reported as presses again after debounce.
  - No release events are generated for state lost by reset.

Decomposition:
- Package keypad_pkg holds:
  - NUM_KEYS=12, KEY_CODE_W=4
  - KEY_STAR=10, KEY_SHARP=11
  - the event struct {code[3:0], pressed}
- Sub-module key_debounce (one instance per key, generated 12 times):
  - Inputs: clk, rst, sample_en, sample.
  - Outputs: state, toggle pulse.
  - Holds the cnt/state logic.
- The top level holds the dwell counter, B_out sequencer, event priority/load logic and overflow.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, round = 48 clocks):
- Idle sequencing: release reset, D_in mux model all keys 0 -> B_out steps 0,1,..,11,0 every 4 clocks; no evt_valid over 10 rounds; B_out never exceeds 11.
- Single press/release of key 3: hold key 3 for 5 rounds with evt_ready=1 -> one event {3,1}, evt_valid one clock after the 3rd key-3 sample, key_state=12'h008. Then release -> one event {3,0}, key_state=0.
- Bounce rejection: key 7 pressed for 2 rounds then released -> no event, key_state[7] stays 0. Then pressed for 3 rounds -> event {7,1}.
- Backpressure/overflow: evt_ready=0, press star (10) then sharp (11) in the same rounds -> buffer holds {10,1}, {11,1} dropped, overflow=1. Then evt_ready=1 -> {10,1} consumed, evt_valid drops. Then pulse ovf_clr -> overflow=0. key_state=12'hC00 throughout after debounce.
- Simultaneous consume+load: hold evt_ready=1 and press keys 0 and 1 together -> events {0,1} then {1,1} on consecutive sample slots, no overflow.
- Reset mid-operation: hold key 9, assert rst for 1 clock mid-round after key_state[9]=1 -> all outputs return to reset values, B_out=0. Then exactly one {9,1} event after 3 rounds, and no release event.
